// File: rtl/bayer_gray_downsample_pkg.sv
// Shared types for the Bayer-to-gray downsampler and the convolution stage
// that consumes its output.
package bayer_gray_downsample_pkg;

    localparam int PIX_W = 12;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Sum of two horizontally adjacent raw pixels.
    typedef logic [PIX_W:0]   pair_sum_t;
    // Sum of a full 2x2 Bayer quad.
    typedef logic [PIX_W+1:0] quad_sum_t;

endpackage

// File: rtl/bayer_gray_downsample_gray_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// No reset on storage or read data so the array maps onto block RAM.
module gray_line_buf
    import bayer_gray_downsample_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int WIDTH = PIX_W + 1,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: data appears one cycle after the request and holds until the next one
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/bayer_gray_downsample.sv
// Collapses each 2x2 RGGB quad of a raster raw stream into one gray pixel
// (sum of the four pixels, truncated divide by 4), halving width and height.
// Even rows store horizontal pair sums in a line buffer; odd rows add their
// own pair sum to the stored one and emit the result one cycle later.
// Optional build macro GRAY_FRAME_STATS_EN adds o_frame_cnt and o_short_frame.
module bayer_gray_downsample
    import bayer_gray_downsample_pkg::*;
#(
    parameter int RAW_WIDTH  = 2560,
    parameter int RAW_HEIGHT = 1920,
    parameter int DATA_WIDTH = PIX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_start,
`ifdef GRAY_FRAME_STATS_EN
    output logic [15:0]           o_frame_cnt,
    output logic                  o_short_frame,
`endif
    output logic                  o_eof
);

    localparam int COL_W  = $clog2(RAW_WIDTH);
    localparam int ROW_W  = $clog2(RAW_HEIGHT);
    localparam int PAIR_W = DATA_WIDTH + 1;
    localparam int QUAD_W = DATA_WIDTH + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RAW_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(RAW_HEIGHT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_take;
    logic                  w_restart;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] r_pair;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [PAIR_W-1:0]     w_pair_sum;
    logic [PAIR_W-1:0]     w_rd_data;
    logic [QUAD_W-1:0]     w_quad_sum;
    logic                  w_out_en;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a frame starts on a qualified sof and ends after its last raw pixel
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_valid && i_sof)  w_state_nxt = ACTIVE;
            ACTIVE:  if (w_take && w_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State outputs: which pixels are accepted, and which restart the raster position
    always_comb begin
        w_take    = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            IDLE: begin
                w_take    = i_valid && i_sof;
                w_restart = i_valid && i_sof;
            end
            ACTIVE: begin
                w_take    = i_valid;
                w_restart = i_valid && i_sof;
            end
            default: begin
                w_take    = 1'b0;
                w_restart = 1'b0;
            end
        endcase
    end

    // A sof pixel is always (0,0), even when it interrupts a frame in progress
    assign w_col      = w_restart ? '0 : r_col;
    assign w_row      = w_restart ? '0 : r_row;
    assign w_col_last = (w_col == COL_LAST);
    assign w_row_last = (w_row == ROW_LAST);
    assign w_last     = w_col_last && w_row_last;

    // Raster counters advance only on accepted pixels; gaps freeze them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_take) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    // Left pixel of each horizontal pair waits here for its right neighbour
    always_ff @(posedge clk) begin
        if (w_take && !w_col[0]) begin
            r_pair <= i_data;
        end
    end

    assign w_pair_sum = {1'b0, r_pair} + {1'b0, i_data};
    assign w_wr_en    = w_take && !w_row[0] &&  w_col[0];
    assign w_rd_en    = w_take &&  w_row[0] && !w_col[0];
    assign w_out_en   = w_take &&  w_row[0] &&  w_col[0];
    assign w_quad_sum = {1'b0, w_rd_data} + {2'b0, r_pair} + {2'b0, i_data};

    gray_line_buf #(
        .DEPTH (RAW_WIDTH / 2),
        .WIDTH (PAIR_W)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_col[COL_W-1:1]),
        .i_wr_data (w_pair_sum),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_col[COL_W-1:1]),
        .o_rd_data (w_rd_data)
    );

    // Output register: one gray pixel per completed quad, o_data holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_start <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= w_out_en;
            o_start <= w_out_en && (w_row == ROW_W'(1)) && (w_col == COL_W'(1));
            o_eof   <= w_out_en && w_last;
            if (w_out_en) begin
                o_data <= w_quad_sum[QUAD_W-1:2];
            end
        end
    end

`ifdef GRAY_FRAME_STATS_EN
    // Completed-frame counter and sticky flag for frames cut short by a new sof
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frame_cnt   <= '0;
            o_short_frame <= 1'b0;
        end else begin
            if (w_take && w_last) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if ((r_state == ACTIVE) && i_valid && i_sof) begin
                o_short_frame <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bayer_gray_downsample.sv
// Directed testbench for bayer_gray_downsample on an 8x4 raw frame.
module tb_bayer_gray_downsample;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sof   = 1'b0;
    logic [11:0] i_data  = '0;
    logic        o_valid;
    logic [11:0] o_data;
    logic        o_start;
    logic        o_eof;
`ifdef GRAY_FRAME_STATS_EN
    logic [15:0] o_frame_cnt;
    logic        o_short_frame;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] data;
        logic        start;
        logic        eof;
    } out_t;

    out_t outq[$];
    int   frm[NPIX];

    // Quad frame: pixel(r,c) = 100*(c+1) + 200*r
    int quad_frm[NPIX] = '{
        100, 200, 300, 400, 500, 600, 700, 800,
        300, 400, 500, 600, 700, 800, 900, 1000,
        500, 600, 700, 800, 900, 1000, 1100, 1200,
        700, 800, 900, 1000, 1100, 1200, 1300, 1400};
    int quad_exp[8] = '{250, 450, 650, 850, 650, 850, 1050, 1250};

    int trunc_frm[NPIX] = '{
        1, 1, 3, 3, 5, 5, 8, 8,
        1, 0, 3, 3, 6, 5, 9, 9,
        4095, 4095, 0, 0, 2, 2, 10, 10,
        4095, 4094, 0, 3, 2, 1, 10, 10};
    int trunc_exp[8] = '{0, 3, 5, 8, 4094, 0, 1, 10};

    bayer_gray_downsample #(
        .RAW_WIDTH  (W),
        .RAW_HEIGHT (H),
        .DATA_WIDTH (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_sof         (i_sof),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_start       (o_start),
`ifdef GRAY_FRAME_STATS_EN
        .o_frame_cnt   (o_frame_cnt),
        .o_short_frame (o_short_frame),
`endif
        .o_eof         (o_eof)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid === 1'b1) outq.push_back({o_data, o_start, o_eof});
    end

    task automatic drive(input bit v, input bit sof, input int d);
        @(negedge clk);
        i_valid = v;
        i_sof   = sof;
        i_data  = d[11:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
    endtask

    task automatic send(input int first, input int last, input bit sof_first, input bit gapped);
        for (int i = first; i <= last; i++) begin
            drive(1'b1, sof_first && (i == first), frm[i]);
            if (gapped) idle(1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", o_data); end
        checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", o_start); end
        checks++; if (o_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", o_eof); end
`ifdef GRAY_FRAME_STATS_EN
        checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); end
        checks++; if (o_short_frame !== 1'b0) begin errors++; $display("FAIL reset_short: got %b want 0", o_short_frame); end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_quad_average();
        outq.delete();
        frm = quad_frm;
        send(0, 9, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL quad_latency_valid: got %b want 1", o_valid); end
        checks++; if (o_data !== 12'd250) begin errors++; $display("FAIL quad_first_data: got %0d want 250", o_data); end
        checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL quad_first_start: got %b want 1", o_start); end
        checks++; if (o_eof !== 1'b0) begin errors++; $display("FAIL quad_first_eof: got %b want 0", o_eof); end
        drive(1'b0, 1'b0, 0);
        checks++; if (o_valid !== 1'b0 || o_start !== 1'b0) begin errors++; $display("FAIL quad_pulse: got valid=%b start=%b want 0 0", o_valid, o_start); end
        checks++; if (o_data !== 12'd250) begin errors++; $display("FAIL quad_data_hold: got %0d want 250", o_data); end
        send(10, NPIX - 1, 1'b0, 1'b0);
        idle(3);
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL quad_count: got %0d want 8", outq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                checks++; if (outq[i].data !== 12'(quad_exp[i])) begin errors++; $display("FAIL quad_data[%0d]: got %0d want %0d", i, outq[i].data, quad_exp[i]); end
                checks++; if (outq[i].start !== (i == 0) || outq[i].eof !== (i == 7)) begin errors++; $display("FAIL quad_flags[%0d]: got start=%b eof=%b", i, outq[i].start, outq[i].eof); end
            end
        end
    endtask

    task automatic test_saturation();
        outq.delete();
        for (int i = 0; i < NPIX; i++) frm[i] = 4095;
        send(0, NPIX - 1, 1'b1, 1'b0);
        idle(3);
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL sat_count: got %0d want 8", outq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                checks++; if (outq[i].data !== 12'd4095) begin errors++; $display("FAIL sat_data[%0d]: got %0d want 4095", i, outq[i].data); end
                checks++; if (outq[i].start !== (i == 0) || outq[i].eof !== (i == 7)) begin errors++; $display("FAIL sat_flags[%0d]: got start=%b eof=%b", i, outq[i].start, outq[i].eof); end
            end
        end
    endtask

    task automatic test_truncation();
        outq.delete();
        frm = trunc_frm;
        send(0, NPIX - 1, 1'b1, 1'b0);
        idle(3);
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL trunc_count: got %0d want 8", outq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                checks++; if (outq[i].data !== 12'(trunc_exp[i])) begin errors++; $display("FAIL trunc_data[%0d]: got %0d want %0d", i, outq[i].data, trunc_exp[i]); end
            end
        end
    endtask

    task automatic test_gapped();
        int neof;
        outq.delete();
        frm = quad_frm;
        send(0, 15, 1'b1, 1'b1);
        idle(3);
        checks++; if (outq.size() != 4) begin errors++; $display("FAIL gap_row1_count: got %0d want 4", outq.size()); end
        send(16, NPIX - 1, 1'b0, 1'b1);
        idle(3);
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL gap_count: got %0d want 8", outq.size()); end
        neof = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                if (outq[i].eof === 1'b1) neof++;
                checks++; if (outq[i].data !== 12'(quad_exp[i])) begin errors++; $display("FAIL gap_data[%0d]: got %0d want %0d", i, outq[i].data, quad_exp[i]); end
            end
        end
        checks++; if (neof != 1 || outq.size() < 8 || outq[7].eof !== 1'b1) begin errors++; $display("FAIL gap_eof: got %0d eof pulses want 1 on last", neof); end
    endtask

    task automatic test_restart();
`ifdef GRAY_FRAME_STATS_EN
        logic [15:0] cnt_before;
`endif
        outq.delete();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, int'($urandom_range(0, 4095)));
        idle(3);
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL idle_filter: got %0d outputs want 0", outq.size()); end
        frm = quad_frm;
        send(0, 20, 1'b1, 1'b0);
`ifdef GRAY_FRAME_STATS_EN
        cnt_before = o_frame_cnt;
        checks++; if (cnt_before !== 16'd4) begin errors++; $display("FAIL stats_cnt_pre: got %0d want 4", cnt_before); end
        checks++; if (o_short_frame !== 1'b0) begin errors++; $display("FAIL stats_short_pre: got %b want 0", o_short_frame); end
`endif
        send(0, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0);
`ifdef GRAY_FRAME_STATS_EN
        checks++; if (o_short_frame !== 1'b1) begin errors++; $display("FAIL stats_short: got %b want 1", o_short_frame); end
        checks++; if (o_frame_cnt !== cnt_before) begin errors++; $display("FAIL stats_cnt_abort: got %0d want %0d", o_frame_cnt, cnt_before); end
`endif
        send(1, NPIX - 1, 1'b0, 1'b0);
        idle(3);
        checks++; if (outq.size() != 12) begin errors++; $display("FAIL restart_count: got %0d want 12", outq.size()); end
        for (int i = 0; i < 12; i++) begin
            if (i < outq.size()) begin
                checks++; if (outq[i].data !== 12'(quad_exp[(i < 4) ? i : i - 4])) begin errors++; $display("FAIL restart_data[%0d]: got %0d want %0d", i, outq[i].data, quad_exp[(i < 4) ? i : i - 4]); end
                checks++; if (outq[i].start !== (i == 0 || i == 4) || outq[i].eof !== (i == 11)) begin errors++; $display("FAIL restart_flags[%0d]: got start=%b eof=%b", i, outq[i].start, outq[i].eof); end
            end
        end
`ifdef GRAY_FRAME_STATS_EN
        checks++; if (o_frame_cnt !== 16'd5) begin errors++; $display("FAIL stats_cnt_post: got %0d want 5", o_frame_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        frm = quad_frm;
        send(0, 11, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0);
        checks++; if (o_valid !== 1'b1 || o_data !== 12'd450) begin errors++; $display("FAIL arst_pre: got valid=%b data=%0d want 1 450", o_valid, o_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_data !== 12'd0 || o_start !== 1'b0 || o_eof !== 1'b0) begin errors++; $display("FAIL arst_clear: got valid=%b data=%0d start=%b eof=%b want all 0", o_valid, o_data, o_start, o_eof); end
`ifdef GRAY_FRAME_STATS_EN
        checks++; if (o_frame_cnt !== 16'd0 || o_short_frame !== 1'b0) begin errors++; $display("FAIL arst_stats: got cnt=%0d short=%b want 0 0", o_frame_cnt, o_short_frame); end
`endif
        #1 rst = 1'b0;
        outq.delete();
        send(12, 15, 1'b0, 1'b0);
        idle(3);
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL arst_idle: got %0d outputs want 0", outq.size()); end
        send(0, NPIX - 1, 1'b1, 1'b0);
        idle(3);
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL arst_count: got %0d want 8", outq.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                checks++; if (outq[i].data !== 12'(quad_exp[i])) begin errors++; $display("FAIL arst_data[%0d]: got %0d want %0d", i, outq[i].data, quad_exp[i]); end
                checks++; if (outq[i].start !== (i == 0) || outq[i].eof !== (i == 7)) begin errors++; $display("FAIL arst_flags[%0d]: got start=%b eof=%b", i, outq[i].start, outq[i].eof); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_quad_average();
        test_saturation();
        test_truncation();
        test_gapped();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayer_gray_downsample.md
Name: bayer_gray_downsample

Overview:
- Upstream feeder of the 3x3 convolution stage.
- Accepts a raster-scan raw Bayer stream (12-bit, RGGB) from the camera capture path.
- Collapses each 2x2 Bayer quad into one 12-bit grayscale pixel, halving width and height.
- Emits a valid-qualified gray stream whose line length (default 1280) matches the convolution line buffers. A first-pixel start pulse drives the convolution `start` input.

Parameters:
- RAW_WIDTH, 2560, raw pixels per line; must be even, ≥4.
- RAW_HEIGHT, 1920, raw lines per frame; must be even, ≥2.
- DATA_WIDTH, 12, raw and gray pixel width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- i_valid  in  1  raw pixel valid this cycle.
- i_sof  in  1  start of frame; qualified by i_valid; marks raw pixel (row 0, col 0).
- i_data  in  DATA_WIDTH  raw Bayer pixel.
- o_valid  out  1  gray pixel valid.
- o_data  out  DATA_WIDTH  gray pixel.
- o_start  out  1  high with o_valid on the first gray pixel of a frame.
- o_eof  out  1  high with o_valid on the last gray pixel of a frame.

Behaviour:
- Reset: one clock, clk; asynchronous active-high reset rst.
  - All outputs 0; state IDLE; counters 0.
  - Line buffer contents undefined, not reset.
- No backpressure: one raw pixel per cycle maximum. Gaps (i_valid=0) are allowed anywhere and freeze all counters.
- FSM states:
  - IDLE: i_valid without i_sof is ignored. i_valid&i_sof goes to ACTIVE and that pixel is processed as col 0, row 0.
  - ACTIVE: process each valid pixel. Return to IDLE after the pixel at (RAW_HEIGHT-1, RAW_WIDTH-1).
- i_sof in ACTIVE (early restart): counters reset, pixel taken as (0,0), no o_eof for the aborted frame. Stale buffer contents are harmless because row 0 rewrites them.
- Counters:
  - col: 0..RAW_WIDTH-1, wraps to 0.
  - row: 0..RAW_HEIGHT-1, increments on col wrap.
- Even row:
  - Even col: hold pixel in a pair register.
  - Odd col: write the 13-bit pair sum (pair reg + i_data) to line buffer index col>>1.
  - Line buffer: depth RAW_WIDTH/2, 13 bits, 1-cycle synchronous read.
- Odd row:
  - Even col: issue buffer read at col>>1 and hold the pixel.
  - Odd col: form the 14-bit sum = buffer data + pair reg + i_data.
  - Next cycle: o_data = sum[13:2] (truncate, no rounding), o_valid=1.
- Latency: o_valid is asserted exactly 1 cycle after the odd-row/odd-col input pixel; registered output.
- Output rate: one gray pixel per 4 raw pixels. RAW_WIDTH/2 outputs per odd raw row.
- o_start: set on the output from raw (1,1).
- o_eof: set on the output from raw (RAW_HEIGHT-1, RAW_WIDTH-1).
- o_valid, o_start, o_eof are single-cycle pulses, otherwise 0. o_data holds its last value when o_valid=0.

Optional Feature:
- Macro GRAY_FRAME_STATS_EN.
- Defined:
  - Adds output o_frame_cnt (16 bits): completed frames, incremented with o_eof, wraps at 65535→0, reset 0.
  - Adds output o_short_frame (1 bit): sticky flag set when i_sof arrives in ACTIVE; cleared by rst only.
- Undefined: neither port exists; core behaviour identical.

Decomposition:
- Shared package holds:
  - state enum typedef (IDLE, ACTIVE);
  - PIX_W=12 constant;
  - the pair-sum (13-bit) and quad-sum (14-bit) typedefs, reused by the convolution stage.
- One sub-module: gray_line_buf (simple dual-port RAM, 1-cycle read, parameterised depth/width), intended for block RAM inference.

Test Plan (RAW_WIDTH=8, RAW_HEIGHT=4 unless noted):
- Quad average: sof frame with row0 = 100,200,…; row1 = 300,400,… → first o_valid 1 cycle after raw (1,1), o_data=250, o_start=1.
- Saturation path: all pixels 4095 → 8 outputs, each 4095, no overflow; o_eof on the 8th only.
- Truncation: quad 1,1,1,0 → o_data=0; quad 3,3,3,3 → 3.
- Gapped input: same frame with i_valid toggling 1/0 → identical o_data sequence, 4 outputs per odd row, o_eof once.
- Early restart and IDLE filtering:
  - i_valid pixels before any sof → no outputs.
  - i_sof at raw (2,5) → counters restart, next output from new (1,1) carries o_start, no o_eof for the aborted frame.
  - With GRAY_FRAME_STATS_EN: o_short_frame=1, o_frame_cnt unchanged.
- Async reset mid-row: rst pulse between clk edges at raw (1,3) → outputs 0 immediately, IDLE. The next sof frame produces correct values.
